bus_2_arbiter: RTL and testbench

BUS_2_ARBITER -- requirements
Module: bus_2_arbiter

---
 rtl/bus_2_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_2_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_2_arbiter.sv
// bus_2_arbiter: round-robin arbiter for the three Bus_2 sources with an
// optional hold-time preemption.
//
// Optional feature macro: BUS2_ARB_TIMEOUT_EN
//   defined   -> an owner that has held the bus for MAX_HOLD cycles is
//                preempted when another source is waiting (timeout pulses)
//   undefined -> an owner keeps the bus until it releases; timeout is 0
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   req[2:0]       in   bit0 = ALU result, bit1 = Bus_1, bit2 = memory word
//   grant[2:0]     out  registered grant, one-hot or zero, bit order as req
//   Sel_Bus_2_Mux  out  registered mux select (0 ALU, 1 Bus_1, 2 memory)
//   busy           out  registered, high while any grant bit is high
//   timeout        out  registered one-cycle pulse on forced preemption
module bus_2_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [1:0] Sel_Bus_2_Mux,
    output logic       busy,
    output logic       timeout
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Last value the hold counter may reach; it saturates here.
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic          state_q,      state_d;
    logic [2:0]    grant_q,      grant_d;
    logic [1:0]    sel_q,        sel_d;
    logic          busy_q,       busy_d;
    logic          timeout_q,    timeout_d;
    logic [CW-1:0] hold_cnt_q,   hold_cnt_d;
    logic [1:0]    last_owner_q, last_owner_d;

    logic [1:0]    start_idx;
    logic [1:0]    pick_idx;
    logic          owner_req;
    logic          preempt;

    // Round-robin pick: lowest rotated distance from last_owner+1 wins.
    always_comb begin
        logic [2:0] cand;
        start_idx = (last_owner_q == 2'd2) ? 2'd0 : last_owner_q + 2'd1;
        pick_idx  = 2'd0;
        cand      = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, start_idx} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (req[cand[1:0]]) begin
                pick_idx = cand[1:0];
            end
        end
    end

    // The current owner still wants the bus.
    assign owner_req = |(req & grant_q);

`ifdef BUS2_ARB_TIMEOUT_EN
    // Preempt only at the hold limit and only if someone else is waiting.
    assign preempt = owner_req && (|(req & ~grant_q)) && (hold_cnt_q == HOLD_LAST);
`else
    assign preempt = 1'b0;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        timeout_d    = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = 3'b000;
                busy_d  = 1'b0;
                if (|req) begin
                    state_d      = ST_BUSY;
                    grant_d      = 3'b001 << pick_idx;
                    sel_d        = pick_idx;
                    busy_d       = 1'b1;
                    hold_cnt_d   = '0;
                    last_owner_d = pick_idx;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    // Normal release wins over a same-cycle preemption.
                    state_d = ST_IDLE;
                    grant_d = 3'b000;
                    busy_d  = 1'b0;
                end else if (preempt) begin
                    state_d   = ST_IDLE;
                    grant_d   = 3'b000;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else if (hold_cnt_q < HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 3'b000;
            sel_q        <= 2'd0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            hold_cnt_q   <= '0;
            last_owner_q <= 2'd2;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign grant         = grant_q;
    assign Sel_Bus_2_Mux = sel_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_bus_2_arbiter.sv
// Directed testbench for bus_2_arbiter (default MAX_HOLD = 4).
module tb_bus_2_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    logic [1:0] prev_sel  = 2'd0;
    logic       prev_busy = 1'b0;

    always #5 clk = ~clk;

    bus_2_arbiter #(.MAX_HOLD(4), .CW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .grant         (grant),
        .Sel_Bus_2_Mux (sel),
        .busy          (busy),
        .timeout       (timeout)
    );

    // Advance one edge, then test the always-true output properties.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if ($countones(grant) > 1) begin
            failures++;
            $display("FAIL inv_onehot grant=%b required one-hot or zero", grant);
        end
        checks++;
        if (sel === 2'd3) begin
            failures++;
            $display("FAIL inv_sel_range sel=%0d required 0..2", sel);
        end
        checks++;
        if (busy !== (|grant)) begin
            failures++;
            $display("FAIL inv_busy busy=%b required %b", busy, |grant);
        end
        checks++;
        if (prev_busy === 1'b1 && busy === 1'b1 && sel !== prev_sel) begin
            failures++;
            $display("FAIL inv_sel_stable sel=%0d required %0d", sel, prev_sel);
        end
        prev_sel  = sel;
        prev_busy = busy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 3'b111;
        tick();
        tick();
        checks++;
        if (grant !== 3'b000 || sel !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state grant=%b sel=%0d busy=%b to=%b required 000/0/0/0",
                     grant, sel, busy, timeout);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b001 || sel !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant grant=%b sel=%0d busy=%b required 001/0/1",
                     grant, sel, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] rq [10];
        logic [2:0] eg [10];
        logic [1:0] es [10];
        rq = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b111, 3'b101, 3'b111, 3'b111, 3'b011, 3'b111};
        eg = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
        es = '{2'd0,   2'd0,   2'd0,   2'd1,   2'd1,   2'd1,   2'd2,   2'd2,   2'd2,   2'd0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req = rq[i];
            tick();
            checks++;
            if (grant !== eg[i] || sel !== es[i] || timeout !== 1'b0) begin
                failures++;
                $display("FAIL rr_step%0d grant=%b sel=%0d to=%b required %b/%0d/0",
                         i, grant, sel, timeout, eg[i], es[i]);
            end
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b100;
        tick();
        checks++;
        if (grant !== 3'b100 || sel !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant grant=%b sel=%0d busy=%b required 100/2/1", grant, sel, busy);
        end
        req = 3'b000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (grant !== 3'b000 || sel !== 2'd2 || busy !== 1'b0) begin
                failures++;
                $display("FAIL single_release%0d grant=%b sel=%0d busy=%b required 000/2/0",
                         i, grant, sel, busy);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) req = 3'b011;
            checks++;
            if (grant !== 3'b001 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL to_hold%0d grant=%b to=%b required 001/0", i, grant, timeout);
            end
        end
`ifdef BUS2_ARB_TIMEOUT_EN
        tick();
        checks++;
        if (grant !== 3'b000 || timeout !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL to_preempt grant=%b to=%b busy=%b required 000/1/0", grant, timeout, busy);
        end
        tick();
        checks++;
        if (grant !== 3'b010 || timeout !== 1'b0 || sel !== 2'd1) begin
            failures++;
            $display("FAIL to_next grant=%b to=%b sel=%0d required 010/0/1", grant, timeout, sel);
        end
`else
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (grant !== 3'b001 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL to_noholdlimit%0d grant=%b to=%b required 001/0", i, grant, timeout);
            end
        end
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b000) begin
            failures++;
            $display("FAIL to_release grant=%b required 000", grant);
        end
        tick();
        checks++;
        if (grant !== 3'b010 || sel !== 2'd1) begin
            failures++;
            $display("FAIL to_next grant=%b sel=%0d required 010/1", grant, sel);
        end
`endif
        req = 3'b000;
        tick();
    endtask

    task automatic test_release_at_limit();
        do_reset();
        req = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) req = 3'b011;
            checks++;
            if (grant !== 3'b001) begin
                failures++;
                $display("FAIL rel_hold%0d grant=%b required 001", i, grant);
            end
        end
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b000 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL rel_at_limit grant=%b to=%b required 000/0", grant, timeout);
        end
        tick();
        checks++;
        if (grant !== 3'b010 || sel !== 2'd1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL rel_next grant=%b sel=%0d to=%b required 010/1/0", grant, sel, timeout);
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        req = 3'b001;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (grant !== 3'b001 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL sat_hold%0d grant=%b to=%b required 001/0", i, grant, timeout);
            end
        end
        req = 3'b011;
        tick();
        checks++;
`ifdef BUS2_ARB_TIMEOUT_EN
        if (grant !== 3'b000 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL sat_preempt grant=%b to=%b required 000/1", grant, timeout);
        end
`else
        if (grant !== 3'b001 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL sat_keep grant=%b to=%b required 001/0", grant, timeout);
        end
`endif
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010 || sel !== 2'd1) begin
            failures++;
            $display("FAIL mr_setup grant=%b sel=%0d required 010/1", grant, sel);
        end
        req = 3'b011;
        rst = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b000 || sel !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mr_drop grant=%b sel=%0d busy=%b required 000/0/0", grant, sel, busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b001 || sel !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mr_regrant grant=%b sel=%0d busy=%b required 001/0/1", grant, sel, busy);
        end
        req = 3'b000;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_release_at_limit();
        test_saturate();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
